alu_pipe: RTL and testbench

Pipelined, parametrised successor to the single-cycle ALU. Accepts one operation per cycle over a valid/ready handshake, computes an extended MIPS-style operation set at configurable data width, and delivers Result plus flags after a configurable number of register stages with full backpressure. It sits between the decode/issue logic and writeback in the multi-cycle CPU datapath, and is usable standalone under a bench.

---
 rtl/alu_defs_pkg.sv | 28 ++
 rtl/alu_core.sv | 63 ++++++
 rtl/alu_pipe.sv | 98 +++++++++
 tb/tb_alu_pipe.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_defs_pkg.sv
// Shared ALU definitions: opcode width, ALUOP_* opcode constants and the
// flag bundle carried through the pipeline.
// Build option: ALU_SHIFT_EN (consumed by alu_core) enables SLL/SRL/SRA;
// when undefined those codes decode as undefined operations.
package alu_defs_pkg;

  localparam int unsigned ALUOP_W = 4;

  localparam logic [ALUOP_W-1:0] ALUOP_AND  = 4'b0000;
  localparam logic [ALUOP_W-1:0] ALUOP_OR   = 4'b0001;
  localparam logic [ALUOP_W-1:0] ALUOP_ADD  = 4'b0010;
  localparam logic [ALUOP_W-1:0] ALUOP_SLTU = 4'b0011;
  localparam logic [ALUOP_W-1:0] ALUOP_XOR  = 4'b0100;
  localparam logic [ALUOP_W-1:0] ALUOP_NOR  = 4'b0101;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB  = 4'b0110;
  localparam logic [ALUOP_W-1:0] ALUOP_SLT  = 4'b0111;
  localparam logic [ALUOP_W-1:0] ALUOP_SLL  = 4'b1000;
  localparam logic [ALUOP_W-1:0] ALUOP_SRL  = 4'b1001;
  localparam logic [ALUOP_W-1:0] ALUOP_SRA  = 4'b1010;

  // Status flags that travel with each result
  typedef struct packed {
    logic overflow;
    logic carry_out;
    logic zero;
  } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU, reusable by the single-cycle CPU.
// Ports: A, B (operands; low log2(DATA_WIDTH) bits of B are the shift
// amount), ALUop (4-bit opcode) -> Result, Overflow, CarryOut, Zero.
// Build option: ALU_SHIFT_EN adds the barrel shifters for SLL/SRL/SRA.
module alu_core
  import alu_defs_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [ALUOP_W-1:0]    ALUop,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  Overflow,
  output logic                  CarryOut,
  output logic                  Zero
);

`ifdef ALU_SHIFT_EN
  localparam int unsigned SHW = $clog2(DATA_WIDTH);
`endif

  logic [DATA_WIDTH:0] sum;
  logic [DATA_WIDTH:0] dif;

  // Operation decode; unknown codes fall through to all-zero result
  always_comb begin
    sum      = {1'b0, A} + {1'b0, B};
    // A + ~B + 1: bit W is the no-borrow indication
    dif      = {1'b0, A} + {1'b0, ~B} + (DATA_WIDTH+1)'(1);
    Result   = '0;
    Overflow = 1'b0;
    CarryOut = 1'b0;
    case (ALUop)
      ALUOP_AND:  Result = A & B;
      ALUOP_OR:   Result = A | B;
      ALUOP_XOR:  Result = A ^ B;
      ALUOP_NOR:  Result = ~(A | B);
      ALUOP_ADD: begin
        Result   = sum[DATA_WIDTH-1:0];
        CarryOut = sum[DATA_WIDTH];
        Overflow = (A[DATA_WIDTH-1] == B[DATA_WIDTH-1]) &&
                   (sum[DATA_WIDTH-1] != A[DATA_WIDTH-1]);
      end
      ALUOP_SUB: begin
        Result   = dif[DATA_WIDTH-1:0];
        CarryOut = ~dif[DATA_WIDTH];
        Overflow = (A[DATA_WIDTH-1] != B[DATA_WIDTH-1]) &&
                   (dif[DATA_WIDTH-1] != A[DATA_WIDTH-1]);
      end
      ALUOP_SLTU: Result = DATA_WIDTH'(A < B);
      ALUOP_SLT:  Result = DATA_WIDTH'($signed(A) < $signed(B));
`ifdef ALU_SHIFT_EN
      ALUOP_SLL:  Result = A << B[SHW-1:0];
      ALUOP_SRL:  Result = A >> B[SHW-1:0];
      ALUOP_SRA:  Result = DATA_WIDTH'($signed(A) >>> B[SHW-1:0]);
`endif
      default:    Result = '0;
    endcase
    Zero = (Result == '0);
  end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU: one op per cycle over valid/ready, result and flags
// delivered after STAGES register stages with full backpressure.
// Ports: clk, rst (sync, active-high); in_valid/in_ready, A, B, ALUop,
// in_tag on the input side; out_valid/out_ready, Result, Overflow,
// CarryOut, Zero, out_tag on the output side.
// Build option: ALU_SHIFT_EN (see alu_core) enables shift opcodes.
module alu_pipe
  import alu_defs_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STAGES     = 2,
  parameter int unsigned TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [ALUOP_W-1:0]    ALUop,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  Overflow,
  output logic                  CarryOut,
  output logic                  Zero,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  localparam int unsigned FLAGS_W = $bits(alu_flags_t);
  localparam int unsigned PAY_W   = DATA_WIDTH + FLAGS_W + TAG_WIDTH;

  logic [DATA_WIDTH-1:0] core_result;
  alu_flags_t            core_flags;
  logic [PAY_W-1:0]      core_payload;
  alu_flags_t            out_flags;

  alu_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
    .A        (A),
    .B        (B),
    .ALUop    (ALUop),
    .Result   (core_result),
    .Overflow (core_flags.overflow),
    .CarryOut (core_flags.carry_out),
    .Zero     (core_flags.zero)
  );

  assign core_payload = {core_result, core_flags, in_tag};

  // Stage chain: a stage loads when empty or when its content moves on;
  // the ready path is combinational from out_ready back to in_ready.
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic             v;
    logic [PAY_W-1:0] d;
    logic             adv;
    logic             load;
    logic             src_v;
    logic [PAY_W-1:0] src_d;

    if (i == STAGES - 1) begin : g_last
      assign adv = out_ready;
    end else begin : g_mid
      assign adv = g_stage[i+1].load;
    end

    if (i == 0) begin : g_first
      assign src_v = in_valid;
      assign src_d = core_payload;
    end else begin : g_next
      assign src_v = g_stage[i-1].v;
      assign src_d = g_stage[i-1].d;
    end

    assign load = !v || adv;

    // Payload only captured for real ops, so a stalled or empty stage holds
    always_ff @(posedge clk) begin
      if (rst) begin
        v <= 1'b0;
        d <= '0;
      end else if (load) begin
        v <= src_v;
        if (src_v) begin
          d <= src_d;
        end
      end
    end
  end

  assign in_ready  = !rst && g_stage[0].load;
  assign out_valid = g_stage[STAGES-1].v;
  assign {Result, out_flags, out_tag} = g_stage[STAGES-1].d;
  assign Overflow  = out_flags.overflow;
  assign CarryOut  = out_flags.carry_out;
  assign Zero      = out_flags.zero;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (DATA_WIDTH=32, STAGES=2): the driver
// pushes the hand-computed expectation on each accepted op, the monitor
// pops and compares on each output transfer and checks stall stability.
module tb_alu_pipe;
  import alu_defs_pkg::*;

  typedef struct packed {
    logic [31:0] r;
    logic        o;
    logic        c;
    logic        z;
    logic [3:0]  t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALUop;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Result;
  logic        Overflow;
  logic        CarryOut;
  logic        Zero;
  logic [3:0]  out_tag;

  int   total = 0;
  int   bad   = 0;
  int   n_acc = 0;
  exp_t sb[$];
  exp_t held;
  bit   have_held = 1'b0;

  alu_pipe #(.DATA_WIDTH(32), .STAGES(2), .TAG_WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .ALUop     (ALUop),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .Overflow  (Overflow),
    .CarryOut  (CarryOut),
    .Zero      (Zero),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Offer one op; push its expectation in the cycle it is accepted
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag, input logic [31:0] r,
                       input logic o, input logic c, input logic z);
    bit acc = 1'b0;
    int n = 0;
    in_valid = 1'b1;
    A = a;
    B = b;
    ALUop = op;
    in_tag = tag;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready && !rst;
      if (acc) begin
        sb.push_back('{r: r, o: o, c: c, z: z, t: tag});
        n_acc++;
      end
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    chk("accept", 64'(acc), 64'd1);
  endtask

  // Monitor: compare on each output transfer, check hold while stalled
  always @(negedge clk) begin
    exp_t cur;
    exp_t e;
    cur = '{r: Result, o: Overflow, c: CarryOut, z: Zero, t: out_tag};
    if (rst) begin
      have_held = 1'b0;
    end else if (out_valid) begin
      if (have_held) chk("hold", 64'(cur), 64'(held));
      if (out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got %h expected none", cur);
        end else begin
          e = sb.pop_front();
          chk("out", 64'(cur), 64'(e));
        end
        have_held = 1'b0;
      end else begin
        held = cur;
        have_held = 1'b1;
      end
    end else if (have_held) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      have_held = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    A = '0;
    B = '0;
    ALUop = '0;
    in_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_result", 64'({Result, Overflow, CarryOut, Zero, out_tag}), 64'd0);
    @(posedge clk);
    #1;

    // Latency: visible two cycles after the accepting cycle
    issue(ALUOP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 4'd1, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("lat_early", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("lat_on", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;

    // Directed vectors back to back
    issue(ALUOP_SUB,  32'd5,         32'd7,         4'd2, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0);
    issue(ALUOP_SUB,  32'd9,         32'd9,         4'd3, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    issue(ALUOP_ADD,  32'hFFFF_FFFF, 32'd1,         4'd4, 32'h0000_0000, 1'b0, 1'b1, 1'b1);
    issue(ALUOP_SLT,  32'hFFFF_FFFF, 32'd1,         4'd5, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    issue(ALUOP_SLTU, 32'hFFFF_FFFF, 32'd1,         4'd6, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    issue(ALUOP_NOR,  32'd0,         32'd0,         4'd7, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    issue(4'b1111,    32'h1234_5678, 32'h9ABC_DEF0, 4'd8, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    issue(ALUOP_SUB,  32'h8000_0000, 32'd1,         4'd9, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0);
`ifdef ALU_SHIFT_EN
    issue(ALUOP_SRA,  32'h8000_0000, 32'd4,         4'd10, 32'hF800_0000, 1'b0, 1'b0, 1'b0);
    issue(ALUOP_SLL,  32'd1,         32'd31,        4'd11, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    issue(ALUOP_SRL,  32'h8000_0000, 32'd4,         4'd12, 32'h0800_0000, 1'b0, 1'b0, 1'b0);
`else
    issue(ALUOP_SRA,  32'h8000_0000, 32'd4,         4'd10, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    issue(ALUOP_SLL,  32'd1,         32'd31,        4'd11, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    issue(ALUOP_SRL,  32'h8000_0000, 32'd4,         4'd12, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
`endif

    // Backpressure: 4 ops offered while the consumer stalls for 5 cycles
    repeat (4) @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_acc = 0;
    fork
      begin
        issue(ALUOP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd1, 32'hF000_F000, 1'b0, 1'b0, 1'b0);
        issue(ALUOP_OR,  32'h0F0F_0000, 32'h0000_00F0, 4'd2, 32'h0F0F_00F0, 1'b0, 1'b0, 1'b0);
        issue(ALUOP_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 4'd3, 32'h5555_5555, 1'b0, 1'b0, 1'b0);
        issue(ALUOP_ADD, 32'd3,         32'd4,         4'd4, 32'h0000_0007, 1'b0, 1'b0, 1'b0);
      end
      begin
        repeat (5) @(negedge clk);
        chk("bp_accepted", 64'(n_acc), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    #1;

    // Reset with two ops in flight: they must never emerge
    out_ready = 1'b0;
    issue(ALUOP_ADD, 32'd100, 32'd1, 4'd14, 32'd101, 1'b0, 1'b0, 1'b0);
    issue(ALUOP_ADD, 32'd200, 32'd1, 4'd15, 32'd201, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("rst2_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_out_valid", 64'(out_valid), 64'd0);
    chk("rst2_in_ready_after", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    issue(ALUOP_OR, 32'h0000_0001, 32'h0000_0002, 4'd5, 32'h0000_0003, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("drain", 64'(sb.size()), 64'd0);
    chk("idle_out_valid", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
